// File: rtl/cache_sa_wb_if.sv
// rtl/cache_sa_wb_if.sv - CPU request/response and bridge refill/write-back signal bundle
interface cache_sa_wb_if #(
    parameter int LINE_WORDS = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_op;
    logic [31:0]                req_addr;
    logic [3:0]                 req_wstrb;
    logic [31:0]                req_wdata;
    logic                       resp_valid;
    logic [31:0]                resp_rdata;
    logic                       rd_req;
    logic [31:0]                rd_addr;
    logic                       rd_rdy;
    logic                       ret_valid;
    logic                       ret_last;
    logic [31:0]                ret_data;
    logic                       wr_req;
    logic [31:0]                wr_addr;
    logic [LINE_WORDS*32-1:0]   wr_data;
    logic                       wr_rdy;

    modport slave (
        input  req_valid, req_op, req_addr, req_wstrb, req_wdata,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output req_ready, resp_valid, resp_rdata, rd_req, rd_addr,
        output wr_req, wr_addr, wr_data
    );

    modport master (
        output req_valid, req_op, req_addr, req_wstrb, req_wdata,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  req_ready, resp_valid, resp_rdata, rd_req, rd_addr,
        input  wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/cache_sa_wb.sv
// rtl/cache_sa_wb.sv - N-way set-associative write-back write-allocate data cache, true LRU
module cache_sa_wb #(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    cache_sa_wb_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WRD_W = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_RDREQ, S_REFILL, S_RESP
    } state_t;

    state_t                    state_q;
    logic                      req_ready_q, resp_valid_q, rd_req_q, wr_req_q;
    logic [31:0]               resp_rdata_q;
    logic [31:0]               wr_addr_q;
    logic [LINE_WORDS*32-1:0]  wr_data_q;
    logic                      op_q;
    logic [31:2]               addr_q;
    logic [3:0]                wstrb_q;
    logic [31:0]               wdata_q;
    logic [WAY_W-1:0]          victim_q;
    logic [WRD_W-1:0]          refill_cnt_q;

    logic [TAG_W-1:0]          tag_q   [SETS][WAYS];
    logic [31:0]               data_q  [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0]           valid_q [SETS];
    logic [WAYS-1:0]           dirty_q [SETS];
    logic [WAY_W-1:0]          age_q   [SETS][WAYS];

    logic [TAG_W-1:0]          tag_f;
    logic [IDX_W-1:0]          idx_f;
    logic [WRD_W-1:0]          wrd_f;
    assign tag_f = addr_q[31:OFF_W+IDX_W];
    assign idx_f = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign wrd_f = addr_q[OFF_W-1:2];

    logic                      hit_d;
    logic [WAY_W-1:0]          hit_way_d, victim_d;
    logic [31:0]               hit_word_d, merged_d;

    always_comb begin
        hit_d     = 1'b0;
        hit_way_d = '0;
        victim_d  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_f][w] && tag_q[idx_f][w] == tag_f) begin
                hit_d     = 1'b1;
                hit_way_d = WAY_W'(w);
            end
            if (age_q[idx_f][w] == WAY_W'(WAYS - 1)) victim_d = WAY_W'(w);
        end
        // An invalid way always wins over the LRU way; scanning downwards leaves the lowest one.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_f][w]) victim_d = WAY_W'(w);
        end
        hit_word_d = data_q[idx_f][hit_way_d][wrd_f];
        merged_d   = hit_word_d;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged_d[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && hit_d && op_q) begin
            data_q[idx_f][hit_way_d][wrd_f] <= merged_d;
        end
        if (state_q == S_REFILL && bus.ret_valid) begin
            data_q[idx_f][victim_q][refill_cnt_q] <= bus.ret_data;
            if (bus.ret_last) tag_q[idx_f][victim_q] <= tag_f;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            victim_q     <= '0;
            refill_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        addr_q      <= bus.req_addr[31:2];
                        wstrb_q     <= bus.req_wstrb;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_d) begin
                        if (op_q) dirty_q[idx_f][hit_way_d] <= 1'b1;
                        else      resp_rdata_q <= hit_word_d;
                        for (int w = 0; w < WAYS; w++) begin
                            if (age_q[idx_f][w] < age_q[idx_f][hit_way_d]) begin
                                age_q[idx_f][w] <= age_q[idx_f][w] + WAY_W'(1);
                            end
                        end
                        age_q[idx_f][hit_way_d] <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        // The victim is invalidated now so a partial refill never looks like the old line.
                        victim_q                 <= victim_d;
                        valid_q[idx_f][victim_d] <= 1'b0;
                        dirty_q[idx_f][victim_d] <= 1'b0;
                        if (valid_q[idx_f][victim_d] && dirty_q[idx_f][victim_d]) begin
                            wr_addr_q <= {tag_q[idx_f][victim_d], idx_f, {OFF_W{1'b0}}};
                            for (int k = 0; k < LINE_WORDS; k++) begin
                                wr_data_q[k*32 +: 32] <= data_q[idx_f][victim_d][k];
                            end
                            wr_req_q <= 1'b1;
                            state_q  <= S_WB;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= S_RDREQ;
                        end
                    end
                end
                S_WB: begin
                    if (bus.wr_rdy) begin
                        wr_req_q <= 1'b0;
                        rd_req_q <= 1'b1;
                        state_q  <= S_RDREQ;
                    end
                end
                S_RDREQ: begin
                    if (bus.rd_rdy) begin
                        rd_req_q <= 1'b0;
                        state_q  <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.ret_valid) begin
                        refill_cnt_q <= refill_cnt_q + WRD_W'(1);
                        if (bus.ret_last) begin
                            refill_cnt_q             <= '0;
                            valid_q[idx_f][victim_q] <= 1'b1;
                            dirty_q[idx_f][victim_q] <= 1'b0;
                            state_q                  <= S_LOOKUP;
                        end
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.rd_req     = rd_req_q;
    assign bus.rd_addr    = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign bus.wr_req     = wr_req_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Sits between the CPU load/store stage and the AXI bridge read/write ports.
- Handles one request at a time. The CPU side uses a valid/ready request and a one-cycle response pulse.
- Misses evict a dirty victim line as one burst write, then refill by word burst and replay the lookup.

Parameters:
WAYS, 4, associativity; power of 2, 1..8
SETS, 64, number of sets; power of 2, >=2
LINE_WORDS, 4, 32-bit words per line; power of 2, >=2
(derived) OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(SETS), TAG_W=32-OFF_W-IDX_W

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  cache can accept request
req_op  in  1  0=read, 1=write
req_addr  in  32  byte address; word-aligned
req_wstrb  in  4  write byte enables
req_wdata  in  32  write data
resp_valid  out  1  one-cycle completion pulse (reads and writes)
resp_rdata  out  32  read data, valid with resp_valid
rd_req  out  1  line refill request
rd_addr  out  32  line-aligned refill address
rd_rdy  in  1  bridge accepts rd_req
ret_valid  in  1  refill word valid
ret_last  in  1  final refill word
ret_data  in  32  refill word
wr_req  out  1  victim write-back request
wr_addr  out  32  line-aligned victim address
wr_data  out  LINE_WORDS*32  victim line; word 0 in [31:0]
wr_rdy  in  1  bridge accepts wr_req

Behaviour:
- Address split: tag=[31:OFF_W+IDX_W], index=[OFF_W+IDX_W-1:OFF_W], word=[OFF_W-1:2].
- Tag, valid, dirty, age and data storage are flop arrays read combinationally.
- Reset (async, any state):
  - state=IDLE; all valid and dirty bits=0; age[s][w]=w for every set.
  - req_ready=1; resp_valid=0; rd_req=0; wr_req=0; resp_rdata=0.
  - Data and tag contents are don't-care.
- States: IDLE, LOOKUP, WB, RDREQ, REFILL, RESP.
- IDLE:
  - req_ready=1; all other outputs inactive.
  - req_valid&req_ready latches op/addr/wstrb/wdata into the request buffer; next state LOOKUP.
- req_ready is 0 in every state except IDLE. req_valid is ignored there.
- LOOKUP:
  - Compare the tag against all valid ways of the set.
  - Hit, read: latch word into resp_rdata.
  - Hit, write: merge bytes per wstrb into the word and set dirty.
  - Hit, either op: LRU update; next state RESP.
  - Miss: pick victim = lowest-numbered invalid way; otherwise the way with age=WAYS-1.
  - Victim valid&dirty: latch wr_addr={victim tag,index,0} and wr_data; next state WB.
  - Otherwise next state RDREQ.
- LRU update on access to way h: ways with age<age[h] increment; age[h]=0. Ages stay a permutation of 0..WAYS-1.
- WB: wr_req=1, held with stable addr/data until wr_req&wr_rdy; that cycle next state RDREQ.
- RDREQ: rd_req=1, rd_addr={tag,index,0}, held until rd_rdy; next state REFILL.
- REFILL:
  - Each ret_valid writes ret_data to word refill_cnt of the victim way; refill_cnt increments.
  - ret_valid&ret_last writes the tag; sets valid=1, dirty=0; refill_cnt=0; next state LOOKUP (replay, which hits).
  - ret_last is authoritative: fewer words leave the rest stale; more words than LINE_WORDS wrap the counter.
- RESP: resp_valid=1 for exactly one cycle; next state IDLE.
- Latency:
  - Hit: accept at cycle T, resp_valid at T+2. Back-to-back accepts no closer than 3 cycles.
  - Miss: hit latency + handshake waits + refill beats + 1 replay cycle.
- wr_req and rd_req are never asserted simultaneously. A write-back completes before its refill is requested.

Test Plan:
- Defaults. Reset, read 0x0000_1004 -> rd_req with rd_addr=0x0000_1000. Return 0x11,0x22,0x33,0x44 (last on 4th) -> resp_rdata=0x0000_0022. Re-read -> resp_valid exactly 2 cycles after accept, no rd_req.
- Write 0x0000_1008, wstrb=4'b0011, wdata=0xAAAA_BBBB (hit) -> resp_valid, no memory traffic. Read 0x0000_1008 -> 0x0000_BBBB.
- Read 0x0000, 0x0400, 0x0800, 0x0C00 (set 0, four ways), then re-read 0x0000. Read 0x1000 -> replaces line 0x0400, no wr_req. Read 0x0000 still hits.
- Fill set 0 as above; write 0x0404=0xDEAD_BEEF; touch 0x0000, 0x0800, 0x0C00; read 0x1000.
  - Expect wr_req with wr_addr=0x0000_0400 and wr_data[63:32]=0xDEAD_BEEF.
  - Hold wr_rdy low 5 cycles -> wr_req stable, rd_req stays 0 until the handshake.
- Hold rd_rdy low 3 cycles during a miss, and pulse req_valid with a second request -> rd_req held, req_ready=0, second request not accepted. It is accepted only after resp_valid.
- Assert resetn low mid-REFILL after 2 beats -> rd_req, wr_req, resp_valid drop immediately and req_ready=1. After release, re-reading the same address misses again.
